bus_uart_tx: RTL and testbench
==============================

BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
Parameters, one per line: name, default, meaning.
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries, a power of two from 2 to 16.

Ports, one per line: name, direction, width, meaning.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 addr  input  16  bus byte address; only addr[1:0] are decoded.
REQ-006 cmd  input  2  bus command: 00 read word, 01 write word, 10 read byte, 11 write byte.
REQ-007 run  input  1  request toggle; a request is pending while run != done.
REQ-008 wr_data  input  16  write data.
REQ-009 rd_data  output  16  read data, valid when done toggles.
REQ-010 done  output  1  completion toggle.
REQ-011 tx  output  1  UART serial output, idle high.
REQ-012 irq  output  1  high while the FIFO is empty and the shifter is idle.

Function
REQ-013 Register map (offset = addr[1]): offset 0 is DATA (write-only); offset 2 is STATUS (read-only).
REQ-014 STATUS SHALL be defined as: [0] fifo_full, [1] fifo_empty, [2] shifter_busy, [7:3] fifo_count, [15:8] zero.
REQ-015 A pending request SHALL be serviced at most once: done toggles exactly once per run toggle.
REQ-016 Minimum latency from the run toggle to the done toggle SHALL be 1 cycle.
REQ-017 The bus SHALL be a toggle handshake: the block samples addr, cmd and wr_data only in the cycle it completes a request. Behaviour is undefined if run toggles again before done matches.
REQ-018 Word or byte write to DATA when the FIFO is not full SHALL push wr_data[7:0] and toggle done in the same edge.
REQ-019 Word or byte write to DATA when the FIFO is full SHALL stall: done is withheld and no push occurs until an entry frees. The write then completes on the first edge where fifo_count < FIFO_DEPTH, with no byte lost.
REQ-020 If a stalled write and a shifter pop happen on the same edge, the push SHALL complete on that edge and fifo_count SHALL stay unchanged.
REQ-021 Writes to STATUS SHALL be ignored and SHALL complete in 1 cycle.
REQ-022 Read word SHALL return STATUS for offset 2 and 16'h0000 for offset 0, completing in 1 cycle.
REQ-023 Read byte SHALL return {8'h00, byte}, where byte is STATUS[7:0] when addr[0]=0 and STATUS[15:8] when addr[0]=1. Offset 0 byte reads return 16'h0000.
REQ-024 rd_data SHALL hold its value between reads. Writes SHALL NOT modify rd_data.
REQ-025 The FIFO SHALL be circular: read and write pointers wrap modulo FIFO_DEPTH, and the count is held in 5 bits.
REQ-026 The shifter SHALL use the states IDLE, START, DATA, STOP.
- IDLE -> START when the FIFO is non-empty; the byte is popped on that transition.
- START drives tx=0 for CLKS_PER_BIT cycles.
- DATA drives bits LSB first, each for CLKS_PER_BIT cycles, with a 3-bit bit index.
- STOP drives tx=1 for CLKS_PER_BIT cycles, then goes to IDLE.
REQ-027 Back-to-back bytes SHALL have no idle gap: STOP -> START directly when the FIFO is non-empty at the end of STOP.
REQ-028 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-029 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reload at each bit boundary.
REQ-030 The tx output SHALL be registered.
REQ-031 shifter_busy SHALL be 1 in every state except IDLE.
REQ-032 irq SHALL equal fifo_empty AND NOT shifter_busy, and SHALL be registered.

Reset
REQ-033 While reset_n=0, the block SHALL hold tx=1, done=0, rd_data=16'h0000 and irq=1.
REQ-034 While reset_n=0, the FIFO SHALL be empty (pointers and count at 0), the shifter in IDLE, and the baud counter and bit index at 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately: tx goes high asynchronously and queued bytes are discarded.
REQ-036 Reset asserted while a request is pending SHALL drop the request. The master re-synchronises by clearing run.
REQ-037 After reset_n rises, the first request SHALL be accepted on the first clock edge.

Verification
REQ-038 Scenario "single byte": CLKS_PER_BIT=4, write word 16'h1255 to 0x0000 -> done toggles after 1 cycle. tx frame is 0, 1,0,1,0,1,0,1,0, 1, each bit 4 cycles, 40 cycles total. irq=0 during the frame, then 1.
REQ-039 Scenario "status read": after 2 writes with the shifter busy -> read word 0x0002 returns 16'h0014 (count=2, busy=1). Read byte 0x0003 returns 16'h0000.
REQ-040 Scenario "full stall": FIFO_DEPTH=4, 6 rapid writes 8'hA0..8'hA5 -> the 6th write's done is withheld until the 2nd pop. All 6 bytes appear on tx in order with no gaps between frames.
REQ-041 Scenario "simultaneous push/pop": stalled write coinciding with a pop -> fifo_count stays at 4 and done toggles on that edge.
REQ-042 Scenario "reset mid-frame": reset_n=0 during bit 3 of byte 8'h3C with 2 bytes queued -> tx=1 and STATUS=16'h0002 after release, and no further frames follow.
REQ-043 Scenario "wrap-around": push and transmit 20 bytes 8'h00..8'h13 -> output order is correct across pointer wrap, and count never exceeds 4.

Source files
------------

// File: rtl/bus_uart_tx.sv
// UART transmitter behind a toggle-handshake bus, fed by a circular byte FIFO.
// Offset 0 is DATA (write-only, pushes a byte); offset 2 is STATUS (read-only).

module bus_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [1:0]  cmd,
    input  logic        run,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        done,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  COUNT_FULL = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [15:0]       r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_irq;
    logic              r_done;
    logic [15:0]       r_rd_data;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [4:0]        r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic              w_baud_end;
    logic              w_pop;
    logic              w_pending;
    logic              w_data_write;
    logic              w_push;
    logic              w_complete;
    logic [7:0]        w_head;
    logic [2:0]        w_next_idx;
    logic [15:0]       w_status;
    logic [15:0]       w_rd_value;
    logic [4:0]        w_count_nxt;
    logic              w_busy_nxt;
    logic              w_unused_bits;

    assign w_full     = (r_count == COUNT_FULL);
    assign w_empty    = (r_count == 5'd0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_next_idx = r_bit_idx + 3'd1;

    // A byte leaves the FIFO when the shifter is idle or finishing a stop bit.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));

    assign w_pending    = run ^ r_done;
    assign w_data_write = w_pending && cmd[0] && !addr[1];
    // NOTE: a write to a full FIFO may still land on an edge that also pops, so the count holds.
    assign w_push       = w_data_write && (!w_full || w_pop);
    assign w_complete   = w_pending && (!w_data_write || w_push);

    assign w_status = {8'h00, r_count, w_busy, w_empty, w_full};

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        w_rd_value = 16'h0000;
        if (addr[1]) begin
            if (!cmd[1]) begin
                w_rd_value = w_status;
            end else if (addr[0]) begin
                w_rd_value = {8'h00, w_status[15:8]};
            end else begin
                w_rd_value = {8'h00, w_status[7:0]};
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 5'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 5'd1;
        end
    end

    assign w_busy_nxt = (r_state == S_IDLE) ? w_pop
                      : !((r_state == S_STOP) && w_baud_end && !w_pop);

    assign w_unused_bits = ^{addr[15:2], wr_data[15:8]};

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done    <= 1'b0;
            r_rd_data <= 16'h0000;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= 5'd0;
        end else begin
            if (w_complete) begin
                r_done <= ~r_done;
                if (!cmd[0]) begin
                    r_rd_data <= w_rd_value;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_irq     <= 1'b1;
        end else begin
            r_irq <= (w_count_nxt == 5'd0) && !w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    r_baud <= 16'd0;
                    if (w_pop) begin
                        r_state <= S_START;
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud    <= 16'd0;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= 16'd0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= 16'd0;
                        if (w_pop) begin
                            r_state <= S_START;
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign done    = r_done;
    assign tx      = r_tx;
    assign irq     = r_irq;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Randomised scoreboard bench for bus_uart_tx: a frame-timeline model predicts done
// edges, read data, irq and the tx waveform; monitors compare every cycle.

module tb_bus_uart_tx;

    localparam int CLKS  = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CLKS;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] addr    = 16'h0000;
    logic [1:0]  cmd     = 2'b00;
    logic        run     = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic [15:0] rd_data;
    logic        done;
    logic        tx;
    logic        irq;

    bus_uart_tx #(
        .CLKS_PER_BIT(CLKS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .addr   (addr),
        .cmd    (cmd),
        .run    (run),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .done   (done),
        .tx     (tx),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the number of cycles left in the current frame.
    typedef struct {
        int unsigned at_cyc;
        logic [7:0]  data;
    } frame_t;

    int unsigned cyc = 0;
    int unsigned exp_done_q[$];
    frame_t      exp_frame_q[$];
    logic [7:0]  m_bytes[$];
    logic        m_done = 1'b0;
    logic [15:0] m_rd   = 16'h0000;
    logic        m_irq  = 1'b1;
    int          m_left = 0;

    function automatic logic [15:0] read_value(input logic [15:0] status,
                                               input logic [15:0] a,
                                               input logic [1:0]  c);
        if (!a[1]) return 16'h0000;
        if (!c[1]) return status;
        return a[0] ? {8'h00, status[15:8]} : {8'h00, status[7:0]};
    endfunction

    task automatic model_step();
        logic [15:0] status;
        logic        pop_now;
        logic        push;
        logic        data_wr;
        frame_t      fr;
        status  = {8'h00, 5'(m_bytes.size()), m_left != 0,
                   m_bytes.size() == 0, m_bytes.size() == DEPTH};
        pop_now = (m_bytes.size() != 0) && (m_left <= 1);
        push    = 1'b0;
        if (run != m_done) begin
            data_wr = cmd[0] && !addr[1];
            if (data_wr && ((m_bytes.size() < DEPTH) || pop_now)) push = 1'b1;
            if (!data_wr || push) begin
                m_done = ~m_done;
                exp_done_q.push_back(cyc);
                if (!cmd[0]) m_rd = read_value(status, addr, cmd);
            end
        end
        if (pop_now) begin
            fr.at_cyc = cyc;
            fr.data   = m_bytes.pop_front();
            exp_frame_q.push_back(fr);
            m_left = FRAME;
        end else if (m_left != 0) begin
            m_left--;
        end
        if (push) m_bytes.push_back(wr_data[7:0]);
        m_irq = (m_bytes.size() == 0) && (m_left == 0);
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_bytes.delete();
            exp_done_q.delete();
            exp_frame_q.delete();
            m_done = 1'b0;
            m_rd   = 16'h0000;
            m_irq  = 1'b1;
            m_left = 0;
        end else begin
            cyc++;
            model_step();
        end
    end

    // Bus monitor: done edge timing, rd_data and irq against the model.
    logic last_done = 1'b0;
    always @(negedge clk) begin
        logic tog;
        if (!reset_n) begin
            check("rst_done", 32'(done), 32'd0);
            check("rst_rd_data", 32'(rd_data), 32'h0);
            check("rst_irq", 32'(irq), 32'd1);
            last_done = 1'b0;
        end else begin
            tog       = (done != last_done);
            last_done = done;
            if (exp_done_q.size() != 0 && exp_done_q[0] == cyc) begin
                check("done_toggle", 32'(tog), 32'd1);
                void'(exp_done_q.pop_front());
            end else begin
                check("done_quiet", 32'(tog), 32'd0);
            end
            check("rd_data", 32'(rd_data), 32'(m_rd));
            check("irq", 32'(irq), 32'(m_irq));
        end
    end

    // tx monitor: idle high, otherwise the exact frame waveform predicted by the model.
    function automatic logic frame_bit(input logic [7:0] b, input int s);
        if (s < CLKS) return 1'b0;
        if (s < 9 * CLKS) return b[3'(s / CLKS - 1)];
        return 1'b1;
    endfunction

    logic       rx_active = 1'b0;
    int         rx_s      = 0;
    logic [7:0] rx_byte   = 8'h00;
    always @(negedge clk) begin
        frame_t fr;
        if (!reset_n) begin
            rx_active = 1'b0;
            check("rst_tx", 32'(tx), 32'd1);
        end else begin
            if (!rx_active && exp_frame_q.size() != 0 && exp_frame_q[0].at_cyc == cyc) begin
                fr        = exp_frame_q.pop_front();
                rx_active = 1'b1;
                rx_s      = 0;
                rx_byte   = fr.data;
            end
            if (rx_active) begin
                check("tx_frame", 32'(tx), 32'(frame_bit(rx_byte, rx_s)));
                rx_s++;
                if (rx_s == FRAME) rx_active = 1'b0;
            end else begin
                check("tx_idle", 32'(tx), 32'd1);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where done has caught up.
    task automatic bus_op(input logic [1:0] c, input logic [15:0] a, input logic [15:0] d,
                          output int lat);
        addr    = a;
        cmd     = c;
        wr_data = d;
        run     = ~run;
        lat     = 0;
        while (done != run && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        check("bus_complete", 32'(done), 32'(run));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_to_idle", 32'(irq), 32'd1);
    endtask

    initial begin
        int          lat;
        int          gap;
        logic [1:0]  c;
        logic [15:0] a;
        logic [15:0] d;

        #1 reset_n = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;

        // Single byte, first request straight after reset.
        bus_op(2'b01, 16'h0000, 16'h1255, lat);
        check("single_lat", 32'(lat), 32'd1);
        wait_idle();

        // Status reads with the shifter busy and two bytes queued.
        bus_op(2'b01, 16'h0000, 16'h00F0, lat);
        repeat (2) @(negedge clk);
        bus_op(2'b11, 16'h0000, 16'h0022, lat);
        check("byte_write_lat", 32'(lat), 32'd1);
        bus_op(2'b01, 16'h0001, 16'h0033, lat);
        bus_op(2'b00, 16'h0002, 16'h0000, lat);
        check("status_read_lat", 32'(lat), 32'd1);
        check("status_word", 32'(rd_data), 32'h0014);
        bus_op(2'b10, 16'h0003, 16'h0000, lat);
        check("status_hi_byte", 32'(rd_data), 32'h0000);
        bus_op(2'b10, 16'h0002, 16'h0000, lat);
        bus_op(2'b01, 16'h0002, 16'hFFFF, lat);
        check("status_write_lat", 32'(lat), 32'd1);
        bus_op(2'b00, 16'h0000, 16'h0000, lat);
        check("data_read_zero", 32'(rd_data), 32'h0000);
        wait_idle();

        // Full stall: the sixth write waits for the second pop, which also pushes.
        for (int i = 0; i < 6; i++) begin
            bus_op(2'b01, 16'h0000, 16'(16'h00A0 + i), lat);
            if (i < 5) check("burst_lat", 32'(lat), 32'd1);
            else       check("stall_lat", 32'(lat), 32'(FRAME - 3));
        end
        bus_op(2'b00, 16'h0002, 16'h0000, lat);
        check("status_full", 32'(rd_data), 32'h0025);
        wait_idle();

        // Wrap-around: 20 bytes through the 4-entry FIFO.
        for (int i = 0; i < 20; i++) begin
            bus_op(2'b11, 16'h0000, 16'(i), lat);
            if (i % 5 == 4) begin
                bus_op(2'b00, 16'h0002, 16'h0000, lat);
                check("wrap_count_le_depth", 32'(rd_data[7:3] <= 5'd4), 32'd1);
            end
        end
        wait_idle();

        // Random mix of reads and writes at random spacing.
        for (int i = 0; i < 80; i++) begin
            c = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                c[0] = 1'b1;
                a[1] = 1'b0;
            end
            bus_op(c, a, d, lat);
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) gap = 45;
            repeat (gap) @(negedge clk);
        end
        wait_idle();

        // Reset during data bit 3 of 8'h3C with two bytes queued.
        bus_op(2'b01, 16'h0000, 16'h003C, lat);
        bus_op(2'b01, 16'h0000, 16'h0001, lat);
        bus_op(2'b01, 16'h0000, 16'h0002, lat);
        repeat (17) @(negedge clk);
        #1;
        reset_n = 1'b0;
        run     = 1'b0;
        #1;
        check("tx_async_reset", 32'(tx), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bus_op(2'b00, 16'h0002, 16'h0000, lat);
        check("post_reset_lat", 32'(lat), 32'd1);
        check("post_reset_status", 32'(rd_data), 32'h0002);
        repeat (100) @(negedge clk);

        check("frames_left", 32'(exp_frame_q.size()), 32'd0);
        check("done_left", 32'(exp_done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
